fir_sample_sequencer: RTL and testbench

- Initiator-side driver for the team's 16-tap FIR engine, which uses an input_ready/output_ready strobe protocol.
- Accepts samples from an upstream valid/ready stream into a small FIFO and issues one sample at a time to the FIR.
- Waits for the FIR's done strobe, captures the result one cycle later, and presents it on a downstream valid/ready stream.
- A watchdog flags a FIR that never answers.

---
 rtl/fir_sample_sequencer.sv | 167 ++++++++++++++++
 tb/tb_fir_sample_sequencer.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_sequencer.sv
// fir_sample_sequencer: initiator-side driver for the 16-tap FIR engine.
// Samples from an upstream valid/ready stream are queued in a small FIFO and
// issued to the FIR one at a time with a single-cycle fir_input_ready strobe.
// The result is captured the cycle after fir_output_ready and is presented on a
// downstream valid/ready stream. A saturating watchdog flags a FIR that never
// answers and drops the stuck sample.
//
// Ports:
//   ck, rst_n          clock (rising edge), asynchronous active-low reset
//   s_data/s_valid     upstream sample stream; s_ready = FIFO not full
//   fir_in             registered sample to FIR, stable until the next pop
//   fir_input_ready    one-cycle issue strobe to FIR
//   fir_out            FIR result, valid in the cycle after fir_output_ready
//   fir_output_ready   FIR done strobe (ignored outside WAIT)
//   m_data/m_valid     registered filtered sample, held until m_ready
//   m_ready            downstream accept
//   err_clr            clears timeout_err (a coincident timeout wins)
//   timeout_err        sticky watchdog flag
module fir_sample_sequencer #(
  parameter int unsigned SIZE    = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            ck,
  input  logic            rst_n,
  input  logic [SIZE-1:0] s_data,
  input  logic            s_valid,
  output logic            s_ready,
  output logic [SIZE-1:0] fir_in,
  output logic            fir_input_ready,
  input  logic [SIZE-1:0] fir_out,
  input  logic            fir_output_ready,
  output logic [SIZE-1:0] m_data,
  output logic            m_valid,
  input  logic            m_ready,
  input  logic            err_clr,
  output logic            timeout_err
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StCapture} state_e;

  state_e state_q, state_d;

  logic [SIZE-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [SIZE-1:0] fir_in_q, m_data_q;
  logic            m_valid_q, m_valid_d;
  logic            err_q, err_d;
  logic [WdW-1:0]  wd_q, wd_d;

  logic full, empty, push, pop, slot_free, wd_expire, timeout_hit;

  assign full      = (count_q == CntW'(DEPTH));
  assign empty     = (count_q == '0);
  assign push      = s_valid && !full;
  // The output slot is free if empty now or being drained on this edge, so a
  // capture can never overwrite an unconsumed result.
  assign slot_free = !m_valid_q || m_ready;
  assign pop       = (state_q == StIdle) && !empty && slot_free;
  // The counter reaches TIMEOUT on this edge.
  assign wd_expire = (wd_q >= WdW'(TIMEOUT - 1));
  assign timeout_hit = (state_q == StWait) && !fir_output_ready && wd_expire;

  // State register
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (pop) state_d = StIssue;
      StIssue:   state_d = StWait;
      StWait: begin
        if (fir_output_ready) begin
          state_d = StCapture;
        end else if (wd_expire) begin
          state_d = StIdle;
        end
      end
      StCapture: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    fir_input_ready = (state_q == StIssue);
  end

  // Datapath next-state
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end

    wd_d = wd_q;
    if (state_q == StIssue) begin
      wd_d = '0;
    end else if (state_q == StWait && wd_q != {WdW{1'b1}}) begin
      wd_d = wd_q + WdW'(1);
    end

    m_valid_d = m_valid_q;
    if (state_q == StCapture) begin
      m_valid_d = 1'b1;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end

    err_d = err_q;
    if (timeout_hit) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      fir_in_q  <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
      wd_q      <= '0;
    end else begin
      count_q   <= count_d;
      m_valid_q <= m_valid_d;
      err_q     <= err_d;
      wd_q      <= wd_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        fir_in_q <= mem_q[rd_ptr_q];
      end
      if (state_q == StCapture) m_data_q <= fir_out;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge ck) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  assign s_ready     = !full;
  assign fir_in      = fir_in_q;
  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_fir_sample_sequencer.sv
module tb_fir_sample_sequencer;

  localparam int SIZE    = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int FIR_LAT = 18;
  localparam int IMP [16] = '{-40, -68, 156, 327, -622, -1140, 2250, 7327,
                              7327, 2250, -1140, -622, 327, 156, -68, -40};

  logic            ck = 1'b0;
  logic            rst_n = 1'b0;
  logic [SIZE-1:0] s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [SIZE-1:0] fir_in;
  logic            fir_input_ready;
  logic [SIZE-1:0] fir_out;
  logic            fir_output_ready;
  logic [SIZE-1:0] m_data;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic            err_clr = 1'b0;
  logic            timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 ck = ~ck;

  fir_sample_sequencer #(.SIZE(SIZE), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .ck               (ck),
    .rst_n            (rst_n),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .fir_in           (fir_in),
    .fir_input_ready  (fir_input_ready),
    .fir_out          (fir_out),
    .fir_output_ready (fir_output_ready),
    .m_data           (m_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .err_clr          (err_clr),
    .timeout_err      (timeout_err)
  );

  // FIR stand-in: samples fir_in one cycle after the strobe, raises done in the
  // 18th cycle after the strobe and updates its output on the edge ending it.
  logic                   fir_alive = 1'b1;
  logic                   spur = 1'b0;
  int                     phase;
  logic signed [SIZE-1:0] taps [16];
  logic [SIZE-1:0]        stub_out;
  longint                 stub_acc, stub_sh;

  always_comb begin
    stub_acc = 0;
    for (int j = 0; j < 16; j++) stub_acc += longint'(taps[j]) * longint'(2 * IMP[j]);
    stub_sh = stub_acc >>> 15;
  end

  always @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= 0;
      stub_out <= '0;
      for (int j = 0; j < 16; j++) taps[j] <= '0;
    end else begin
      if (fir_input_ready && fir_alive) phase <= 1;
      else if (phase == FIR_LAT) phase <= 0;
      else if (phase != 0) phase <= phase + 1;
      if (phase == 1) begin
        taps[0] <= fir_in;
        for (int j = 1; j < 16; j++) taps[j] <= taps[j-1];
      end
      if (phase == FIR_LAT) stub_out <= stub_sh[SIZE-1:0];
    end
  end

  assign fir_out          = stub_out;
  assign fir_output_ready = (phase == FIR_LAT) || spur;

  // Reference model: the stream of results is the 16-tap convolution of every
  // sample accepted since reset, taken in acceptance order.
  int hist[$];

  function automatic logic [SIZE-1:0] model_out(input int k);
    longint acc = 0;
    for (int j = 0; j < 16; j++) begin
      if (k - j >= 0) acc += longint'(hist[k-j]) * longint'(2 * IMP[j]);
    end
    acc = acc >>> 15;
    return acc[SIZE-1:0];
  endfunction

  // Passive monitor: records events with their cycle stamps.
  int              cyc = 0;
  logic [SIZE-1:0] got_q[$];
  int              acc_t[$], rise_t[$], strobe_t[$], err_rise_t[$];
  int              late_acc = 0;
  int              hold_viol = 0;
  logic            mv_p = 1'b0, mr_p = 1'b0, rej_p = 1'b0, err_p = 1'b0;
  logic [SIZE-1:0] md_p = '0;

  always @(posedge ck) cyc <= cyc + 1;

  always @(negedge ck) begin
    if (rst_n) begin
      if (s_valid && s_ready) begin
        acc_t.push_back(cyc + 1);
        if (fir_input_ready && rej_p) late_acc++;
      end
      if (m_valid && m_ready) got_q.push_back(m_data);
      if (m_valid && !mv_p) rise_t.push_back(cyc);
      if (fir_input_ready) strobe_t.push_back(cyc);
      if (timeout_err && !err_p) err_rise_t.push_back(cyc);
      if (mv_p && !mr_p && (!m_valid || m_data !== md_p)) hold_viol++;
    end
    mv_p  = m_valid;
    mr_p  = m_ready;
    md_p  = m_data;
    rej_p = s_valid && !s_ready;
    err_p = timeout_err;
  end

  task automatic wait_neg();
    @(negedge ck);
    #1;
  endtask

  task automatic do_reset();
    @(posedge ck);
    #1;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    err_clr = 1'b0;
    spur    = 1'b0;
    repeat (2) @(posedge ck);
    #1;
    rst_n = 1'b1;
    hist.delete();
  endtask

  task automatic push(input logic [SIZE-1:0] d);
    int n = 0;
    @(posedge ck);
    #1;
    s_data  = d;
    s_valid = 1'b1;
    forever begin
      wait_neg();
      if (s_ready) break;
      n++;
      if (n > 400) begin
        errors++;
        $display("FAIL push_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, n);
        break;
      end
    end
    @(posedge ck);
    #1;
    s_valid = 1'b0;
    if (n <= 400) hist.push_back(int'($signed(d)));
  endtask

  task automatic wait_got(input int target, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (got_q.size() >= target) begin
        ok = 1'b1;
        break;
      end
      wait_neg();
    end
  endtask

  task automatic test_reset();
    @(posedge ck);
    #1;
    checks++; if (m_valid !== 1'b0 || fir_input_ready !== 1'b0) begin
      errors++; $display("FAIL reset_hold: m_valid=%0b fir_input_ready=%0b, required 0 0",
                         m_valid, fir_input_ready);
    end
    rst_n = 1'b1;
    wait_neg();
    checks++; if (s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_s_ready: got %0b, required 1", s_ready);
    end
    checks++; if (fir_in !== '0 || m_data !== '0) begin
      errors++; $display("FAIL reset_data: fir_in=%0h m_data=%0h, required 0 0", fir_in, m_data);
    end
    checks++; if (m_valid !== 1'b0 || timeout_err !== 1'b0 || fir_input_ready !== 1'b0) begin
      errors++; $display("FAIL reset_flags: m_valid=%0b timeout_err=%0b fir_input_ready=%0b",
                         m_valid, timeout_err, fir_input_ready);
    end
  endtask

  task automatic test_impulse();
    int gb, ab, rb;
    bit ok;
    do_reset();
    m_ready = 1'b1;
    gb = got_q.size(); ab = acc_t.size(); rb = rise_t.size();
    push(SIZE'(16384));
    for (int i = 0; i < 15; i++) push('0);
    wait_got(gb + 16, 800, ok);
    checks++; if (!ok) begin
      errors++; $display("FAIL impulse_count: got %0d results, required 16", got_q.size() - gb);
    end else begin
      for (int i = 0; i < 16; i++) begin
        logic [SIZE-1:0] e;
        e = SIZE'(IMP[i]);
        checks++; if (got_q[gb+i] !== e) begin
          errors++; $display("FAIL impulse_data[%0d]: got %0d, required %0d",
                             i, $signed(got_q[gb+i]), $signed(e));
        end
      end
      checks++; if (rise_t[rb] - acc_t[ab] != 21) begin
        errors++; $display("FAIL impulse_latency: got %0d cycles, required 21",
                           rise_t[rb] - acc_t[ab]);
      end
      for (int i = 1; i < 16; i++) begin
        checks++; if (rise_t[rb+i] - rise_t[rb+i-1] != 21) begin
          errors++; $display("FAIL impulse_spacing[%0d]: got %0d, required 21",
                             i, rise_t[rb+i] - rise_t[rb+i-1]);
        end
      end
    end
    repeat (30) wait_neg();
    checks++; if (got_q.size() - gb != 16) begin
      errors++; $display("FAIL impulse_total: got %0d, required 16", got_q.size() - gb);
    end
  endtask

  task automatic test_backpressure();
    int gb, sb, hv, n;
    logic [SIZE-1:0] md;
    bit ok;
    do_reset();
    gb = got_q.size(); sb = strobe_t.size(); hv = hold_viol;
    for (int i = 0; i < 5; i++) push(SIZE'($urandom));
    wait_neg();
    checks++; if (s_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full: s_ready=%0b, required 0", s_ready);
    end
    n = 0;
    while (!m_valid && n < 60) begin wait_neg(); n++; end
    md = m_data;
    checks++; if (!m_valid || md !== model_out(0)) begin
      errors++; $display("FAIL bp_first: m_valid=%0b m_data=%0h, required 1 %0h",
                         m_valid, md, model_out(0));
    end
    repeat (30) wait_neg();
    checks++; if (m_valid !== 1'b1 || m_data !== md) begin
      errors++; $display("FAIL bp_hold: m_valid=%0b m_data=%0h, required 1 %0h", m_valid, m_data, md);
    end
    checks++; if (strobe_t.size() - sb != 1) begin
      errors++; $display("FAIL bp_no_issue: got %0d strobes, required 1", strobe_t.size() - sb);
    end
    @(posedge ck);
    #1;
    m_ready = 1'b1;
    wait_got(gb + 5, 400, ok);
    checks++; if (!ok) begin
      errors++; $display("FAIL bp_drain: got %0d results, required 5", got_q.size() - gb);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (got_q[gb+i] !== model_out(i)) begin
          errors++; $display("FAIL bp_data[%0d]: got %0h, required %0h", i, got_q[gb+i], model_out(i));
        end
      end
    end
    checks++; if (hold_viol != hv) begin
      errors++; $display("FAIL bp_stable: got %0d hold violations, required 0", hold_viol - hv);
    end
  endtask

  task automatic test_full_fifo();
    int gb, lb, sb;
    bit ok;
    do_reset();
    m_ready = 1'b1;
    gb = got_q.size(); lb = late_acc; sb = strobe_t.size();
    for (int i = 1; i <= 8; i++) push(SIZE'(i));
    wait_got(gb + 8, 400, ok);
    checks++; if (!ok) begin
      errors++; $display("FAIL full_count: got %0d results, required 8", got_q.size() - gb);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (got_q[gb+i] !== model_out(i)) begin
          errors++; $display("FAIL full_data[%0d]: got %0h, required %0h", i, got_q[gb+i], model_out(i));
        end
      end
    end
    checks++; if (late_acc - lb != 3) begin
      errors++; $display("FAIL full_reject_then_accept: got %0d, required 3", late_acc - lb);
    end
    repeat (25) wait_neg();
    checks++; if (got_q.size() - gb != 8 || strobe_t.size() - sb != 8) begin
      errors++; $display("FAIL full_no_dup: results %0d strobes %0d, required 8 8",
                         got_q.size() - gb, strobe_t.size() - sb);
    end
  endtask

  task automatic test_timeout();
    int sb, eb, rb, n;
    do_reset();
    fir_alive = 1'b0;
    m_ready   = 1'b1;
    sb = strobe_t.size(); eb = err_rise_t.size(); rb = rise_t.size();
    push(SIZE'(100));
    push(SIZE'(200));
    n = 0;
    while (err_rise_t.size() == eb && n < 200) begin wait_neg(); n++; end
    checks++; if (err_rise_t.size() == eb) begin
      errors++; $display("FAIL timeout_rise: timeout_err=%0b, required 1", timeout_err);
    end else begin
      checks++; if (err_rise_t[eb] - strobe_t[sb] != 65) begin
        errors++; $display("FAIL timeout_delay: got %0d, required 65", err_rise_t[eb] - strobe_t[sb]);
      end
    end
    n = 0;
    while (strobe_t.size() < sb + 2 && n < 20) begin wait_neg(); n++; end
    checks++; if (strobe_t.size() != sb + 2) begin
      errors++; $display("FAIL timeout_next_issue: got %0d strobes, required 2", strobe_t.size() - sb);
    end
    @(posedge ck); #1; err_clr = 1'b1;
    @(posedge ck); #1; err_clr = 1'b0;
    wait_neg();
    checks++; if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL timeout_clear: got %0b, required 0", timeout_err);
    end
    @(posedge ck); #1; err_clr = 1'b1;
    n = 0;
    while (err_rise_t.size() < eb + 2 && n < 100) begin wait_neg(); n++; end
    checks++; if (timeout_err !== 1'b1 || err_rise_t.size() != eb + 2) begin
      errors++; $display("FAIL timeout_set_wins: timeout_err=%0b rises=%0d, required 1 2",
                         timeout_err, err_rise_t.size() - eb);
    end
    err_clr = 1'b0;
    checks++; if (rise_t.size() != rb || m_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_no_result: m_valid rises %0d, required 0", rise_t.size() - rb);
    end
    fir_alive = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    int rb, sb;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(SIZE'($urandom_range(1, 1000)));
    repeat (3) wait_neg();
    rb = rise_t.size(); sb = strobe_t.size();
    @(posedge ck); #1; rst_n = 1'b0;
    wait_neg();
    checks++; if (fir_in !== '0 || m_valid !== 1'b0 || fir_input_ready !== 1'b0 ||
                  timeout_err !== 1'b0 || m_data !== '0) begin
      errors++; $display("FAIL midreset_outputs: fir_in=%0h m_valid=%0b m_data=%0h, required 0 0 0",
                         fir_in, m_valid, m_data);
    end
    @(posedge ck); #1;
    @(posedge ck); #1; rst_n = 1'b1;
    hist.delete();
    wait_neg();
    checks++; if (s_ready !== 1'b1 || fir_in !== '0) begin
      errors++; $display("FAIL midreset_release: s_ready=%0b fir_in=%0h, required 1 0", s_ready, fir_in);
    end
    @(posedge ck); #1; spur = 1'b1;
    @(posedge ck); #1; spur = 1'b0;
    repeat (60) wait_neg();
    checks++; if (rise_t.size() != rb || strobe_t.size() != sb || m_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_dropped: rises %0d strobes %0d, required 0 0",
                         rise_t.size() - rb, strobe_t.size() - sb);
    end
  endtask

  task automatic test_spurious();
    int gb, ab, rb, sb;
    bit ok;
    do_reset();
    m_ready = 1'b1;
    gb = got_q.size(); ab = acc_t.size(); rb = rise_t.size(); sb = strobe_t.size();
    @(posedge ck); #1; spur = 1'b1;
    @(posedge ck); #1; spur = 1'b0;
    repeat (5) wait_neg();
    checks++; if (m_valid !== 1'b0 || strobe_t.size() != sb || s_ready !== 1'b1) begin
      errors++; $display("FAIL spurious_ignored: m_valid=%0b strobes=%0d, required 0 0",
                         m_valid, strobe_t.size() - sb);
    end
    push(SIZE'($urandom));
    wait_got(gb + 1, 60, ok);
    checks++; if (!ok || got_q[gb] !== model_out(0) || rise_t[rb] - acc_t[ab] != 21) begin
      errors++; $display("FAIL spurious_then_normal: results=%0d, required 1 with latency 21",
                         got_q.size() - gb);
    end
  endtask

  task automatic test_random_stream();
    int gb, hv;
    logic [SIZE-1:0] d [24];
    do_reset();
    gb = got_q.size(); hv = hold_viol;
    for (int i = 0; i < 24; i++) d[i] = SIZE'($urandom);
    fork
      begin
        for (int i = 0; i < 24; i++) push(d[i]);
      end
      begin
        for (int k = 0; k < 4000 && got_q.size() < gb + 24; k++) begin
          @(posedge ck); #1;
          m_ready = 1'($urandom_range(0, 1));
        end
        m_ready = 1'b1;
      end
    join
    repeat (3) wait_neg();
    checks++; if (got_q.size() - gb != 24) begin
      errors++; $display("FAIL random_count: got %0d, required 24", got_q.size() - gb);
    end else begin
      for (int i = 0; i < 24; i++) begin
        checks++; if (got_q[gb+i] !== model_out(i)) begin
          errors++; $display("FAIL random_data[%0d]: got %0h, required %0h", i, got_q[gb+i], model_out(i));
        end
      end
    end
    checks++; if (hold_viol != hv) begin
      errors++; $display("FAIL random_hold: got %0d hold violations, required 0", hold_viol - hv);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_impulse();
    test_backpressure();
    test_full_fifo();
    test_timeout();
    test_reset_mid_wait();
    test_spurious();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
